led_matrix_scan: RTL and testbench
==================================

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles per row period; legal range is 2 or more.
REQ-002 Parameter BLANK_CYC, default 16, blanked cycles at the start of each row period; legal range is 1 to SCAN_DIV-1.
REQ-003 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port grid  input  64  live generation grid from the evolve/LFSR mux; cell (r,c) SHALL be grid[8*r+c], r,c in 0..7.
REQ-006 Port enable  input  1  scanning permitted while high.
REQ-007 Port row  output  8  one-hot row drive, active-high; bit r drives matrix row r.
REQ-008 Port col  output  8  column drive, active-high; col[c] lights cell (current row, c).
REQ-009 Port frame_done  output  1  one-cycle pulse marking the end of a full 8-row frame.

Function
REQ-010 States SHALL be IDLE, LOAD, BLANK and SHOW; the state register, 3-bit row index, prescaler cnt and 64-bit frame buffer fb SHALL be flops.
REQ-011 IDLE: row=0 and col=0; when enable=1, next state is LOAD.
REQ-012 LOAD (1 cycle): fb<=grid, row index<=0, cnt<=0, next state BLANK; row=0 and col=0.
REQ-013 BLANK: row=0 and col=0; cnt increments; when cnt==BLANK_CYC-1, next state SHOW.
REQ-014 SHOW: row has only bit (row index) set; col[c]=fb[8*(row index)+c]; cnt increments.
REQ-015 In SHOW with cnt==SCAN_DIV-1: cnt<=0; if row index<7, row index increments and next state is BLANK.
REQ-016 In SHOW with cnt==SCAN_DIV-1 and row index==7: frame_done<=1 for exactly the next cycle, and next state is LOAD.
REQ-017 fb SHALL change only in LOAD; grid changes at any other time SHALL NOT affect row or col (tear-free display).
REQ-018 Each row period SHALL be exactly SCAN_DIV cycles: BLANK_CYC blanked cycles, then SCAN_DIV-BLANK_CYC lit cycles.
REQ-019 A frame SHALL be exactly 1+8*SCAN_DIV cycles, counted from a LOAD to the next LOAD.
REQ-020 row and col SHALL be decoded only from registered state, with no combinational path from grid or enable.
REQ-021 enable=0 in any state: next state SHALL be IDLE, row index and cnt SHALL be cleared to 0, fb SHALL be held, and frame_done SHALL be 0.
REQ-022 A partially shown frame interrupted by enable=0 SHALL NOT produce a frame_done pulse.
REQ-023 If enable=0 coincides with the row-7 terminal count, IDLE SHALL win and frame_done SHALL stay 0.
REQ-024 Re-assertion of enable SHALL always restart from LOAD at row 0 with a fresh grid capture.
REQ-025 cnt SHALL be ceil(log2(SCAN_DIV)) bits wide and SHALL never exceed SCAN_DIV-1; the row index SHALL wrap from 7 to 0 only through LOAD.

Reset
REQ-026 While reset=0: state=IDLE, row index=0, cnt=0, fb=0, row=0, col=0, frame_done=0, applied asynchronously.
REQ-027 Reset asserted mid-frame SHALL clear all state immediately, independent of clk.
REQ-028 After reset deasserts, the first rising edge with enable=1 SHALL enter LOAD.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-029 Reset release, enable=1, grid=64'h8040201008040201 -> for each row r in turn: 1 blank cycle, then 3 cycles with row=1<<r and col=1<<r; frame_done pulses once per 33-cycle frame.
REQ-030 grid changes to 64'hFFFF..FF during row 3 of a frame -> rows 3-7 still show the old pattern; the next frame shows col=8'hFF on every row.
REQ-031 enable dropped during row 5 SHOW -> row=0 and col=0 on the next cycle, no frame_done; re-enable -> LOAD, then row 0 shown first.
REQ-032 reset asserted asynchronously mid-SHOW (between clock edges) -> row, col and frame_done read 0 before the next edge.
REQ-033 enable=0 exactly on the row-7 terminal cycle -> frame_done stays 0 and state goes to IDLE.
REQ-034 grid=64'h00000000000000FF held constant -> col=8'hFF only while row=8'h01; all other rows show col=0.

Source files
------------

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver: latches a 64-bit grid once per frame
// and scans it row by row, with a blanked lead-in on every row period.
module led_matrix_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        enable,
  output logic [7:0]  row,
  output logic [7:0]  col,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, BLANK, SHOW} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ridx_q, ridx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      fb_q, fb_d;
  logic             fd_q, fd_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ridx_q  <= '0;
      cnt_q   <= '0;
      fb_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ridx_q  <= ridx_d;
      cnt_q   <= cnt_d;
      fb_q    <= fb_d;
      fd_q    <= fd_d;
    end
  end

  // Dropping enable overrides everything, including the row-7 terminal count.
  always_comb begin
    state_d = state_q;
    ridx_d  = ridx_q;
    cnt_d   = cnt_q;
    fb_d    = fb_q;
    fd_d    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      ridx_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          fb_d    = grid;
          ridx_d  = '0;
          cnt_d   = '0;
          state_d = BLANK;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (ridx_q == 3'd7) begin
              fd_d    = 1'b1;
              state_d = LOAD;
            end else begin
              ridx_d  = ridx_q + 3'd1;
              state_d = BLANK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Drive lines come only from flops, so grid changes cannot tear the picture.
  always_comb begin
    row = '0;
    col = '0;
    if (state_q == SHOW) begin
      row = 8'd1 << ridx_q;
      col = fb_q[{ridx_q, 3'b000} +: 8];
    end
  end

  assign frame_done = fd_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: a frame-position model predicts
// row/col/frame_done per edge; predictions are queued and compared after each edge.
module tb_led_matrix_scan;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = 1 + 8 * SCAN_DIV;
  localparam logic [63:0] DIAG = 64'h8040201008040201;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] grid;
  logic [7:0]  row, col;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb_q[$];
  logic [16:0] e;

  // Model: position within a frame, 0 = LOAD cycle, 1..FRAME-1 = row periods.
  bit          m_active;
  int          m_p;
  logic [63:0] m_fb;
  logic        m_fd;

  led_matrix_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .reset(reset), .grid(grid), .enable(enable),
    .row(row), .col(col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model_out();
    logic [7:0] r_o;
    logic [7:0] c_o;
    int r, off;
    r_o = '0;
    c_o = '0;
    if (m_active && m_p >= 1) begin
      r   = (m_p - 1) / SCAN_DIV;
      off = (m_p - 1) % SCAN_DIV;
      if (off >= BLANK_CYC) begin
        r_o = 8'd1 << r;
        c_o = m_fb[8*r +: 8];
      end
    end
    return {r_o, c_o, m_fd};
  endfunction

  task automatic model_reset();
    m_active = 0; m_p = 0; m_fb = '0; m_fd = 1'b0;
  endtask

  task automatic tick();
    if (!reset) model_reset();
    else if (!enable) begin m_active = 0; m_p = 0; m_fd = 1'b0; end
    else if (!m_active) begin m_active = 1; m_p = 0; m_fd = 1'b0; end
    else if (m_p == 0) begin m_fb = grid; m_p = 1; m_fd = 1'b0; end
    else if (m_p == FRAME - 1) begin m_p = 0; m_fd = 1'b1; end
    else begin m_p++; m_fd = 1'b0; end
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; grid = DIAG;
    model_reset();
    #3;
    checks++;
    if ({row, col, frame_done} !== 17'h0) begin
      errors++; $display("FAIL reset_async: got %h %h %b, want 0 0 0", row, col, frame_done);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL reset_hold: got %h %h %b, want %h", row, col, frame_done, e);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_diagonal();
    int pulses, first_t, last_t;
    pulses = 0; first_t = -1; last_t = -1;
    for (int t = 1; t <= 2 * FRAME + 1; t++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL diag t=%0d: got %h %h %b, want %h", t, row, col, frame_done, e);
      end
      if (row != 8'h00) begin
        checks++;
        if (col !== row) begin
          errors++; $display("FAIL diag_col t=%0d: got %h, want %h", t, col, row);
        end
      end
      if (frame_done === 1'b1) begin
        pulses++;
        if (first_t < 0) first_t = t; else last_t = t;
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL diag_pulses: got %0d, want 2", pulses);
    end
    checks++;
    if (last_t - first_t != FRAME) begin
      errors++; $display("FAIL diag_period: got %0d, want %0d", last_t - first_t, FRAME);
    end
  endtask

  task automatic test_tear_free();
    int fr;
    logic [7:0] want;
    fr = 0;
    grid = DIAG;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (i > 0 && m_p == 0) fr++;
      e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL tear i=%0d: got %h %h %b, want %h", i, row, col, frame_done, e);
      end
      if (row != 8'h00) begin
        want = (fr == 0) ? row : 8'hFF;
        checks++;
        if (col !== want) begin
          errors++; $display("FAIL tear_col fr=%0d: got %h, want %h", fr, col, want);
        end
      end
      if (fr == 0 && m_p == 1 + 3 * SCAN_DIV + BLANK_CYC) grid = '1;
    end
  endtask

  task automatic test_enable_drop();
    grid = DIAG;
    for (int i = 0; i < 2 * FRAME && m_p != 1 + 5 * SCAN_DIV + BLANK_CYC; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL drop_run: got %h %h %b, want %h", row, col, frame_done, e);
      end
    end
    checks++;
    if (row !== 8'h20 || col !== 8'h20) begin
      errors++; $display("FAIL drop_row5: got %h %h, want 20 20", row, col);
    end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e || {row, col, frame_done} !== 17'h0) begin
        errors++; $display("FAIL drop_idle: got %h %h %b, want 0 0 0", row, col, frame_done);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL drop_restart: got %h %h %b, want %h", row, col, frame_done, e);
      end
    end
    checks++;
    if (row !== 8'h01 || col !== 8'h01) begin
      errors++; $display("FAIL drop_row0: got %h %h, want 01 01", row, col);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * FRAME && m_p != 2 + 2 * SCAN_DIV + BLANK_CYC; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL arst_run: got %h %h %b, want %h", row, col, frame_done, e);
      end
    end
    checks++;
    if (row === 8'h00) begin
      errors++; $display("FAIL arst_pre: got row %h, want nonzero", row);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({row, col, frame_done} !== 17'h0) begin
      errors++; $display("FAIL arst_mid: got %h %h %b, want 0 0 0", row, col, frame_done);
    end
    tick(); e = sb_q.pop_front(); checks++;
    if ({row, col, frame_done} !== e) begin
      errors++; $display("FAIL arst_hold: got %h %h %b, want %h", row, col, frame_done, e);
    end
    reset = 1'b1;
  endtask

  task automatic test_terminal_disable();
    grid = DIAG;
    for (int i = 0; i < 2 * FRAME + 2 && m_p != FRAME - 1; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL term_run: got %h %h %b, want %h", row, col, frame_done, e);
      end
    end
    checks++;
    if (row !== 8'h80) begin
      errors++; $display("FAIL term_row7: got %h, want 80", row);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e || frame_done !== 1'b0) begin
        errors++; $display("FAIL term_idle: got %h %h %b, want %h", row, col, frame_done, e);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_single_row();
    logic [7:0] want;
    grid = 64'h00000000000000FF;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick(); e = sb_q.pop_front(); checks++;
      if ({row, col, frame_done} !== e) begin
        errors++; $display("FAIL single: got %h %h %b, want %h", row, col, frame_done, e);
      end
      want = (row == 8'h01) ? 8'hFF : 8'h00;
      checks++;
      if (col !== want) begin
        errors++; $display("FAIL single_col row=%h: got %h, want %h", row, col, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_diagonal();
    test_tear_free();
    test_enable_drop();
    test_async_reset();
    test_terminal_disable();
    test_single_row();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
